bcd_conv_scheduler: RTL

//  Shares one 14-bit binary-to-BCD converter between NUM_REQ requesters (score, high score, ...).

---
 rtl/bcd_conv_scheduler_pkg.sv | 17 +
 rtl/bcd_conv_scheduler_rr_arbiter.sv | 31 +++
 rtl/bcd_conv_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/bcd_conv_scheduler_pkg.sv
// Shared constants and FSM encoding for the BCD converter scheduler.
// The defaults match the 14-bit, 14-cycle converter used by the score display.
package bcd_sched_pkg;

    localparam int CONV_BIN_W   = 14;
    localparam int CONV_LAT_CYC = 14;
    localparam int BCD_MAX_VAL  = 9999;
    localparam int BCD_W        = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_conv_scheduler_rr_arbiter.sv
// Combinational round-robin pick: the first set pending bit at or after start_idx,
// wrapping around. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [ID_W-1:0]    start_idx,
    output logic [ID_W-1:0]    grant_id,
    output logic               any_req
);

    // Walk from the far end back toward start_idx so the nearest set bit wins last.
    always_comb begin
        int idx;
        idx      = 0;
        grant_id = '0;
        any_req  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(start_idx) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (pending[ID_W'(idx)]) begin
                grant_id = ID_W'(idx);
                any_req  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Time-shares one binary-to-BCD converter between NUM_REQ requesters and keeps
// each requester's latest 4-digit BCD result for the display.
module bcd_conv_scheduler
    import bcd_sched_pkg::*;
#(
    parameter int  NUM_REQ  = 2,
    parameter int  BIN_W    = CONV_BIN_W,
    parameter int  CONV_LAT = CONV_LAT_CYC,
    parameter int  MAX_VAL  = BCD_MAX_VAL,
    localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*BIN_W-1:0] bin_in,
    output logic                     conv_start,
    output logic [BIN_W-1:0]         conv_in,
    input  logic [BCD_W-1:0]         conv_bcd,
    output logic [NUM_REQ*BCD_W-1:0] result,
    output logic [NUM_REQ-1:0]       result_valid,
    output logic                     done,
    output logic [ID_W-1:0]          done_id,
    output logic                     busy,
    output state_t                   dbg_state
);

    // Handshake: conv_start is a one-cycle pulse in ISSUE with conv_in already
    // stable; conv_bcd is trusted CONV_LAT edges later. done is a one-cycle
    // pulse aligned with the updated result slice named by done_id.

    localparam int                CNT_W    = $clog2(CONV_LAT + 1);
    localparam logic [BIN_W-1:0]  MAX_BIN  = BIN_W'(MAX_VAL);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(CONV_LAT - 1);

    state_t               state;
    state_t               state_nxt;
    logic [NUM_REQ-1:0]   pending;
    logic [NUM_REQ-1:0]   grant_mask;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      next_ptr;
    logic [ID_W-1:0]      grant_id;
    logic [ID_W-1:0]      arb_id;
    logic                 arb_any;
    logic                 grant_now;
    logic [CNT_W-1:0]     wait_cnt;
    logic [BIN_W-1:0]     grant_val;
    logic [BIN_W-1:0]     bin_arr    [NUM_REQ];
    logic [BCD_W-1:0]     result_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign bin_arr[i]                  = bin_in[i*BIN_W +: BIN_W];
        assign result[i*BCD_W +: BCD_W]    = result_arr[i];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .pending   (pending),
        .start_idx (rr_ptr),
        .grant_id  (arb_id),
        .any_req   (arb_any)
    );

    assign grant_now  = (state == ST_IDLE) && arb_any;
    assign grant_mask = grant_now ? (NUM_REQ'(1) << arb_id) : '0;
    assign next_ptr   = (arb_id == ID_W'(NUM_REQ - 1)) ? '0 : arb_id + 1'b1;
    assign grant_val  = (bin_arr[arb_id] > MAX_BIN) ? MAX_BIN : bin_arr[arb_id];
    assign busy       = (state != ST_IDLE);
    assign dbg_state  = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        conv_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_any) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                conv_start = 1'b1;
                state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // A request sampled on its own grant edge survives the clear: one queued re-run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending      <= '0;
            rr_ptr       <= '0;
            grant_id     <= '0;
            wait_cnt     <= '0;
            conv_in      <= '0;
            result_valid <= '0;
            done         <= 1'b0;
            done_id      <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                result_arr[i] <= '0;
            end
        end else begin
            done    <= 1'b0;
            pending <= (pending & ~grant_mask) | req;
            if (grant_now) begin
                grant_id <= arb_id;
                rr_ptr   <= next_ptr;
                conv_in  <= grant_val;
            end
            if (state == ST_ISSUE) begin
                wait_cnt <= CNT_LOAD;
            end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (state == ST_CAPTURE) begin
                result_arr[grant_id]   <= conv_bcd;
                result_valid[grant_id] <= 1'b1;
                done                   <= 1'b1;
                done_id                <= grant_id;
            end
        end
    end

endmodule
